dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer driving a DDS/DAC stage.
// Define DDS_SWEEP_DOWN_EN to allow downward sweeps when start > stop.
module dds_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_start_fw,
    input  logic [31:0]        cfg_stop_fw,
    input  logic [31:0]        cfg_step_fw,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [31:0]        cfg_pha_word,
    input  logic [2:0]         cfg_wave_type,
    input  logic               cfg_loop,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        fre_word,
    output logic [31:0]        pha_word,
    output logic [2:0]         wave_type,
    output logic               busy,
    output logic               done
);
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t state, state_nx;
    logic [31:0] sh_start, sh_stop, sh_step, sh_pha;
    logic [31:0] run_start, run_stop, run_step;
    logic [DWELL_W-1:0] sh_dwell, run_dwell, cnt;
    logic [2:0] sh_wave;
    logic sh_loop, run_loop, run_fl, last;
    logic go, adv, fin, sh_fl, sat;
    logic [32:0] nxt;
`ifdef DDS_SWEEP_DOWN_EN
    logic run_down;
    assign sh_fl = sh_start == sh_stop;
    assign nxt = run_down ? {1'b0, fre_word} - {1'b0, run_step} : {1'b0, fre_word} + {1'b0, run_step};
    assign sat = nxt[32] || run_step == '0 || (run_down ? nxt[31:0] <= run_stop : nxt[31:0] >= run_stop);
`else
    assign sh_fl = sh_start >= sh_stop;
    assign nxt = {1'b0, fre_word} + {1'b0, run_step};
    assign sat = nxt[32] || run_step == '0 || nxt[31:0] >= run_stop;
`endif
    assign cfg_ready = state == IDLE;
    assign busy = state == SWEEP;
    assign go = cfg_ready && start && !abort;
    assign adv = busy && !abort && cnt == run_dwell;
    assign fin = adv && last && !run_loop;
    always_comb begin
        state_nx = state;
        if (go)
            state_nx = SWEEP;
        else if (busy && (abort || fin))
            state_nx = IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // Sweep runs from run_* copies so a config accepted alongside start waits for the next start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_start  <= '0;
            sh_stop   <= '0;
            sh_step   <= '0;
            sh_dwell  <= '0;
            sh_pha    <= '0;
            sh_wave   <= '0;
            sh_loop   <= 1'b0;
            run_start <= '0;
            run_stop  <= '0;
            run_step  <= '0;
            run_dwell <= '0;
            run_loop  <= 1'b0;
            run_fl    <= 1'b0;
`ifdef DDS_SWEEP_DOWN_EN
            run_down  <= 1'b0;
`endif
            last      <= 1'b0;
            cnt       <= '0;
            fre_word  <= '0;
            pha_word  <= '0;
            wave_type <= '0;
            done      <= 1'b0;
        end else begin
            done <= fin;
            if (cfg_valid && cfg_ready) begin
                sh_start <= cfg_start_fw;
                sh_stop  <= cfg_stop_fw;
                sh_step  <= cfg_step_fw;
                sh_dwell <= cfg_dwell;
                sh_pha   <= cfg_pha_word;
                sh_wave  <= cfg_wave_type;
                sh_loop  <= cfg_loop;
            end
            if (go) begin
                run_start <= sh_start;
                run_stop  <= sh_stop;
                run_step  <= sh_step;
                run_dwell <= sh_dwell;
                run_loop  <= sh_loop;
                run_fl    <= sh_fl;
`ifdef DDS_SWEEP_DOWN_EN
                run_down  <= sh_start > sh_stop;
`endif
                last      <= sh_fl;
                cnt       <= '0;
                fre_word  <= sh_start;
                pha_word  <= sh_pha;
                wave_type <= sh_wave;
            end else if (busy && !abort) begin
                if (adv) begin
                    cnt <= '0;
                    if (!last) begin
                        fre_word <= sat ? run_stop : nxt[31:0];
                        last     <= sat;
                    end else if (run_loop) begin
                        fre_word <= run_start;
                        last     <= run_fl;
                    end
                end else
                    cnt <= cnt + DWELL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: table-driven sweep vectors with a per-cycle scoreboard,
// plus hand-written reset, continuous/abort and handshake sequences.
module tb_dds_sweep_ctrl;
    logic clock = 1'b0, reset = 1'b1, cfg_valid = 1'b0, cfg_loop = 1'b0, start = 1'b0, abort = 1'b0;
    logic [31:0] cfg_start_fw = '0, cfg_stop_fw = '0, cfg_step_fw = '0, cfg_pha_word = '0;
    logic [15:0] cfg_dwell = '0;
    logic [2:0]  cfg_wave_type = '0;
    logic cfg_ready, busy, done;
    logic [31:0] fre_word, pha_word;
    logic [2:0]  wave_type;
    int tests = 0, fails = 0;

    typedef struct {
        logic [31:0] s, e, st;
        logic [15:0] dw;
        logic [2:0]  wv;
        logic [31:0] ph;
        int          n;
        logic [31:0] last;
    } vec_t;
    typedef struct {
        logic [31:0] fre;
        logic        busy;
        logic        done;
    } exp_t;
    exp_t q[$];
    vec_t tv[7];

    dds_sweep_ctrl #(.DWELL_W(16)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start_fw(cfg_start_fw), .cfg_stop_fw(cfg_stop_fw), .cfg_step_fw(cfg_step_fw),
        .cfg_dwell(cfg_dwell), .cfg_pha_word(cfg_pha_word), .cfg_wave_type(cfg_wave_type),
        .cfg_loop(cfg_loop), .start(start), .abort(abort), .fre_word(fre_word),
        .pha_word(pha_word), .wave_type(wave_type), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v, input logic lp);
        @(negedge clock);
        cfg_valid = 1'b1;
        cfg_start_fw = v.s;
        cfg_stop_fw = v.e;
        cfg_step_fw = v.st;
        cfg_dwell = v.dw;
        cfg_wave_type = v.wv;
        cfg_pha_word = v.ph;
        cfg_loop = lp;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    // Expected per-cycle outputs of a single sweep: each value dwell+1 cycles, then a done cycle.
    task automatic build(input vec_t v);
        logic [31:0] f;
        logic [32:0] nx;
        bit fin, sat, dn;
        f = v.s;
        dn = 1'b0;
`ifdef DDS_SWEEP_DOWN_EN
        dn = v.s > v.e;
        fin = v.s == v.e;
`else
        fin = v.s >= v.e;
`endif
        for (int g = 0; g < 64; g++) begin
            for (int k = 0; k <= int'(v.dw); k++)
                q.push_back('{f, 1'b1, 1'b0});
            if (fin)
                break;
            if (dn) begin
                nx = {1'b0, f} - {1'b0, v.st};
                sat = nx[32] || v.st == 0 || nx[31:0] <= v.e;
            end else begin
                nx = {1'b0, f} + {1'b0, v.st};
                sat = nx[32] || v.st == 0 || nx[31:0] >= v.e;
            end
            f = sat ? v.e : nx[31:0];
            fin = sat;
        end
        q.push_back('{f, 1'b0, 1'b1});
    endtask

    task automatic run(input string nm, input vec_t v);
        exp_t x;
        int nb;
        build(v);
        nb = 0;
        @(negedge clock);
        start = 1'b1;
        while (q.size() > 0) begin
            @(negedge clock);
            start = 1'b0;
            x = q.pop_front();
            chk({nm, " fre"}, fre_word, x.fre);
            chk({nm, " busy"}, 32'(busy), 32'(x.busy));
            chk({nm, " done"}, 32'(done), 32'(x.done));
            if (busy)
                nb++;
        end
        chk({nm, " cycles"}, 32'(nb), 32'(v.n));
        chk({nm, " last"}, fre_word, v.last);
        chk({nm, " wave"}, 32'(wave_type), 32'(v.wv));
        chk({nm, " pha"}, pha_word, v.ph);
        @(negedge clock);
        chk({nm, " done clr"}, 32'(done), 32'd0);
        chk({nm, " ready"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        vec_t z, h;
        exp_t x;
        tv[0] = '{32'd100, 32'd400, 32'd100, 16'd2, 3'd2, 32'h11111111, 12, 32'd400};
        tv[1] = '{32'hFFFFFF00, 32'hFFFFFFFF, 32'h200, 16'd0, 3'd1, 32'h22, 2, 32'hFFFFFFFF};
`ifdef DDS_SWEEP_DOWN_EN
        tv[2] = '{32'd500, 32'd200, 32'd100, 16'd1, 3'd4, 32'h33, 8, 32'd200};
`else
        tv[2] = '{32'd500, 32'd200, 32'd100, 16'd1, 3'd4, 32'h33, 2, 32'd500};
`endif
        tv[3] = '{32'd50, 32'd90, 32'd0, 16'd0, 3'd3, 32'h44, 2, 32'd90};
        tv[4] = '{32'd10, 32'd35, 32'd5, 16'd3, 3'd0, 32'h55, 24, 32'd35};
        tv[5] = '{32'd7, 32'd7, 32'd1, 16'd0, 3'd1, 32'h66, 1, 32'd7};
        tv[6] = '{32'd0, 32'd25, 32'd10, 16'd0, 3'd2, 32'h77, 4, 32'd25};

        repeat (2) @(negedge clock);
        chk("rst fre", fre_word, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("post rst ready", 32'(cfg_ready), 32'd1);
        chk("post rst done", 32'(done), 32'd0);

        for (int i = 0; i < 7; i++) begin
            load(tv[i], 1'b0);
            run($sformatf("vec%0d", i), tv[i]);
        end

        // Reset mid-sweep, then a start with cleared shadows sweeps 0..0.
        load(tv[0], 1'b0);
        @(negedge clock);
        start = 1'b1;
        repeat (5) @(negedge clock) start = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst fre", fre_word, 32'd0);
        chk("arst pha", pha_word, 32'd0);
        chk("arst wave", 32'(wave_type), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst ready", 32'(cfg_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("arst no done", 32'(done), 32'd0);
            chk("arst idle", 32'(busy), 32'd0);
        end
        z = '{32'd0, 32'd0, 32'd0, 16'd0, 3'd0, 32'd0, 1, 32'd0};
        run("zero shadow", z);

        // Continuous sweep with abort.
        h = '{32'd10, 32'd30, 32'd10, 16'd0, 3'd1, 32'h5, 0, 32'd0};
        load(h, 1'b1);
        for (int i = 0; i < 7; i++)
            q.push_back('{32'(10 * (i % 3 + 1)), 1'b1, 1'b0});
        @(negedge clock);
        start = 1'b1;
        while (q.size() > 0) begin
            @(negedge clock);
            start = 1'b0;
            x = q.pop_front();
            chk("loop fre", fre_word, x.fre);
            chk("loop busy", 32'(busy), 32'd1);
            chk("loop done", 32'(done), 32'd0);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort fre", fre_word, 32'd10);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clock);
        chk("abort done2", 32'(done), 32'd0);
        chk("abort ready", 32'(cfg_ready), 32'd1);

        // Config offered with start: running sweep keeps old values; start in SWEEP ignored.
        h = '{32'd100, 32'd400, 32'd100, 16'd2, 3'd1, 32'h1234, 12, 32'd400};
        load(h, 1'b0);
        build(h);
        @(negedge clock);
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_wave_type = 3'd3;
        cfg_pha_word = 32'hABCD;
        cfg_stop_fw = 32'd200;
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clock);
            start = i == 4;
            cfg_valid = 1'b0;
            x = q.pop_front();
            chk("hs fre", fre_word, x.fre);
            chk("hs done", 32'(done), 32'(x.done));
            chk("hs wave", 32'(wave_type), 32'd1);
            if (x.busy)
                chk("hs ready", 32'(cfg_ready), 32'd0);
        end
        h = '{32'd100, 32'd200, 32'd100, 16'd2, 3'd3, 32'hABCD, 6, 32'd200};
        run("hs next", h);

        // start with abort in IDLE stays idle.
        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("sa busy", 32'(busy), 32'd0);
        chk("sa ready", 32'(cfg_ready), 32'd1);
        @(negedge clock);
        chk("sa done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
